// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer.
// Holds the 3-bit state encoding, the FSM state type, default sizing and a
// helper that picks a counter width wide enough for every counted phase.
package scan_pkg;

    localparam int unsigned DEFAULT_CHAIN_LEN = 16;
    localparam int unsigned DEFAULT_CAP_W     = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
    localparam logic [2:0] ST_CAPTURE   = 3'd2;
    localparam logic [2:0] ST_SHIFT_OUT = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        StIdle     = ST_IDLE,
        StShiftIn  = ST_SHIFT_IN,
        StCapture  = ST_CAPTURE,
        StShiftOut = ST_SHIFT_OUT,
        StDone     = ST_DONE
    } state_e;

    // Counter holds CHAIN_LEN-1 for shifting and cap_cycles-1 for capture.
    function automatic int unsigned cnt_width(input int unsigned chain_len,
                                              input int unsigned cap_w);
        int unsigned w;
        w = $clog2(chain_len);
        return (w > cap_w) ? w : cap_w;
    endfunction

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Bundle of the scan sequencer's request and DUT-side signals.
//   slave  : sequencer view (start/abort/pat_in/cap_cycles/op_en/scan_out in;
//            sen/scan_in/dut_val_op/busy/done/res_out out)
//   master : requester / chain view (directions reversed)
interface scan_seq_ctrl_if import scan_pkg::*; #(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned CAP_W     = DEFAULT_CAP_W
) ();

    logic                 start;
    logic                 abort;
    logic [CHAIN_LEN-1:0] pat_in;
    logic [CAP_W-1:0]     cap_cycles;
    logic                 op_en;
    logic                 scan_out;
    logic                 sen;
    logic                 scan_in;
    logic                 dut_val_op;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] res_out;

    modport slave (
        input  start, abort, pat_in, cap_cycles, op_en, scan_out,
        output sen, scan_in, dut_val_op, busy, done, res_out
    );

    modport master (
        output start, abort, pat_in, cap_cycles, op_en, scan_out,
        input  sen, scan_in, dut_val_op, busy, done, res_out
    );

endinterface

// File: rtl/scan_seq_cnt.sv
// Loadable down-counter with zero flag, shared by the shift-in, capture and
// shift-out phases.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (wins over dec)
//   dec        : decrement, saturating at zero
//   zero       : count is zero
module scan_seq_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan test sequencer: shifts a pattern into a DUT scan chain (LSB first),
// runs a number of functional capture cycles, then unloads the chain.
//   clk, reset : clock, synchronous active-high reset
//   bus        : request inputs, DUT chain strobes, busy/done status, res_out
// All outputs come from registers or the state register only.
module scan_seq_ctrl import scan_pkg::*; #(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned CAP_W     = DEFAULT_CAP_W
) (
    input  logic           clk,
    input  logic           reset,
    scan_seq_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W    = cnt_width(CHAIN_LEN, CAP_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_e               state_q, state_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] res_q, res_d;
    logic [CHAIN_LEN-1:0] res_out_q, res_out_d;
    logic [CAP_W-1:0]     cap_q, cap_d;
    logic                 op_en_q, op_en_d;
    logic                 dvo_q, dvo_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    scan_seq_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        res_d     = res_q;
        res_out_d = res_out_q;
        cap_d     = cap_q;
        op_en_d   = op_en_q;
        dvo_d     = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = LAST_BIT;
        cnt_dec   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StShiftIn;
                    pat_d    = bus.pat_in;
                    // zero capture cycles still runs one
                    cap_d    = (bus.cap_cycles == '0) ? CAP_W'(1) : bus.cap_cycles;
                    op_en_d  = bus.op_en;
                    cnt_load = 1'b1;
                end
            end
            StShiftIn: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    pat_d = pat_q >> 1;
                    if (cnt_zero) begin
                        state_d  = StCapture;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(cap_q - CAP_W'(1));
                        // registered so the strobe lands on the first capture cycle
                        dvo_d    = op_en_q;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            StCapture: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    state_d  = StShiftOut;
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StShiftOut: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    res_d = {bus.scan_out, res_q[CHAIN_LEN-1:1]};
                    if (cnt_zero) begin
                        state_d   = StDone;
                        // visible on res_out during the done cycle
                        res_out_d = res_d;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            res_q     <= '0;
            res_out_q <= '0;
            cap_q     <= '0;
            op_en_q   <= 1'b0;
            dvo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            res_q     <= res_d;
            res_out_q <= res_out_d;
            cap_q     <= cap_d;
            op_en_q   <= op_en_d;
            dvo_q     <= dvo_d;
        end
    end

    assign bus.sen        = (state_q == StShiftIn) || (state_q == StShiftOut);
    assign bus.scan_in    = (state_q == StShiftIn) && pat_q[0];
    assign bus.dut_val_op = dvo_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.res_out    = res_out_q;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl with a 16-stage chain model that shifts
// toward stage 0 while sen=1 and holds otherwise.
module tb_scan_seq_ctrl;

    localparam int unsigned CL   = 16;
    localparam int unsigned CW   = 4;
    localparam int          NCYC = 44;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    scan_seq_ctrl_if #(.CHAIN_LEN(CL), .CAP_W(CW)) bus ();

    scan_seq_ctrl #(
        .CHAIN_LEN (CL),
        .CAP_W     (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // DUT scan chain model
    logic [CL-1:0] chain;
    always @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else if (bus.sen) begin
            chain <= {bus.scan_in, chain[CL-1:1]};
        end
    end
    assign bus.scan_out = chain[0];

    int checks = 0;
    int errors = 0;

    logic [NCYC-1:0] sen_log, si_log, dvo_log, busy_log, done_log;
    logic [CL-1:0]   res_log [NCYC];
    logic [CL-1:0]   si_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic log_cycle(input int c);
        sen_log[c]  = bus.sen;
        si_log[c]   = bus.scan_in;
        dvo_log[c]  = bus.dut_val_op;
        busy_log[c] = bus.busy;
        done_log[c] = bus.done;
        res_log[c]  = bus.res_out;
    endtask

    function automatic int first_set(input logic [NCYC-1:0] v);
        for (int i = 0; i < NCYC; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Cycle 0 is the cycle start is presented in IDLE; extra events are
    // one-cycle pulses at the given cycle numbers (-1 = none).
    task automatic run(input logic [CL-1:0] pat, input logic [CW-1:0] cap, input logic op,
                       input int abort_a, input int abort_b, input int start2_at,
                       input int reset_at);
        bus.pat_in     = pat;
        bus.cap_cycles = cap;
        bus.op_en      = op;
        bus.start      = 1'b1;
        bus.abort      = (abort_a == 0) || (abort_b == 0);
        reset          = 1'b0;
        log_cycle(0);
        for (int c = 1; c < NCYC; c++) begin
            step();
            bus.start = (c == start2_at);
            if (c == start2_at) bus.pat_in = '1;
            bus.abort = (c == abort_a) || (c == abort_b);
            reset     = (c == reset_at);
            log_cycle(c);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
        step();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pat_in     = '0;
        bus.cap_cycles = '0;
        bus.op_en      = 1'b0;
        reset          = 1'b1;
        repeat (3) step();

        check("rst_sen",     32'(bus.sen),        32'd0);
        check("rst_scan_in", 32'(bus.scan_in),    32'd0);
        check("rst_dvo",     32'(bus.dut_val_op), 32'd0);
        check("rst_busy",    32'(bus.busy),       32'd0);
        check("rst_done",    32'(bus.done),       32'd0);
        check("rst_res",     32'(bus.res_out),    32'd0);
        reset = 1'b0;
        step();

        // Basic pass, one capture cycle, no op strobe
        run(16'hA5C3, 4'd1, 1'b0, -1, -1, -1, -1);
        for (int c = 1; c <= 16; c++) si_word[c-1] = si_log[c];
        check("t1_scan_in_seq", 32'(si_word),            32'hA5C3);
        check("t1_busy_c0",     32'(busy_log[0]),        32'd0);
        check("t1_busy_c1",     32'(busy_log[1]),        32'd1);
        check("t1_sen_c1",      32'(sen_log[1]),         32'd1);
        check("t1_sen_c17",     32'(sen_log[17]),        32'd0);
        check("t1_sen_c18",     32'(sen_log[18]),        32'd1);
        check("t1_done_cyc",    32'(first_set(done_log)), 32'd34);
        check("t1_done_cnt",    32'($countones(done_log)), 32'd1);
        check("t1_dvo_cnt",     32'($countones(dvo_log)), 32'd0);
        check("t1_res_at_done", 32'(res_log[34]),        32'hA5C3);
        check("t1_busy_c35",    32'(busy_log[35]),       32'd0);
        check("t1_res_hold",    32'(bus.res_out),        32'hA5C3);

        // cap_cycles=0 behaves as 1; abort with start in IDLE and abort in DONE
        run(16'h0001, 4'd0, 1'b0, 0, 34, -1, -1);
        check("t2_done_cyc",  32'(first_set(done_log)),  32'd34);
        check("t2_done_cnt",  32'($countones(done_log)), 32'd1);
        check("t2_sen_c17",   32'(sen_log[17]),          32'd0);
        check("t2_sen_c18",   32'(sen_log[18]),          32'd1);
        check("t2_res",       32'(res_log[34]),          32'h0001);

        // Three capture cycles with op strobe
        run(16'h5A3C, 4'd3, 1'b1, -1, -1, -1, -1);
        check("t3_sen_16",    32'(sen_log[16]),          32'd1);
        check("t3_sen_17_19", 32'(sen_log[19:17]),       32'd0);
        check("t3_sen_20",    32'(sen_log[20]),          32'd1);
        check("t3_dvo_cyc",   32'(first_set(dvo_log)),   32'd17);
        check("t3_dvo_cnt",   32'($countones(dvo_log)),  32'd1);
        check("t3_done_cyc",  32'(first_set(done_log)),  32'd36);
        check("t3_res",       32'(bus.res_out),          32'h5A3C);

        // Start while busy is ignored
        run(16'h3C5A, 4'd1, 1'b0, -1, -1, 5, -1);
        check("t4_done_cyc",  32'(first_set(done_log)),  32'd34);
        check("t4_done_cnt",  32'($countones(done_log)), 32'd1);
        check("t4_res",       32'(bus.res_out),          32'h3C5A);

        // Abort during shift-out
        run(16'h00FF, 4'd1, 1'b0, 25, -1, -1, -1);
        check("t5_busy_c25",  32'(busy_log[25]),         32'd1);
        check("t5_busy_c26",  32'(busy_log[26]),         32'd0);
        check("t5_sen_c26",   32'(sen_log[26]),          32'd0);
        check("t5_done_cnt",  32'($countones(done_log)), 32'd0);
        check("t5_res_keep",  32'(bus.res_out),          32'h3C5A);

        // Reset during capture
        run(16'h1234, 4'd1, 1'b1, -1, -1, -1, 17);
        check("t6_dvo_c17",   32'(dvo_log[17]),          32'd1);
        check("t6_sen_c18",   32'(sen_log[18]),          32'd0);
        check("t6_si_c18",    32'(si_log[18]),           32'd0);
        check("t6_dvo_c18",   32'(dvo_log[18]),          32'd0);
        check("t6_busy_c18",  32'(busy_log[18]),         32'd0);
        check("t6_done_cnt",  32'($countones(done_log)), 32'd0);
        check("t6_res_c18",   32'(res_log[18]),          32'd0);

        // Normal test after reset
        run(16'hBEEF, 4'd2, 1'b1, -1, -1, -1, -1);
        check("t7_dvo_cyc",   32'(first_set(dvo_log)),   32'd17);
        check("t7_dvo_cnt",   32'($countones(dvo_log)),  32'd1);
        check("t7_done_cyc",  32'(first_set(done_log)),  32'd35);
        check("t7_res",       32'(res_log[35]),          32'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
